// File: rtl/mips_wb_pkg.sv
// Shared constants for the writeback path: register/data widths and requester indices.
package mips_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: selects a first and a second requester, with an
// override vector that jumps the queue and an exclusion mask for the second pick.
module wb_rr_pick #(
    parameter  int NREQ  = 3,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  cand,
    input  logic [IDX_W-1:0] start,
    input  logic [NREQ-1:0]  ovr,
    input  logic [NREQ-1:0]  excl,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_vld,
    output logic [IDX_W-1:0] second_idx,
    output logic             second_vld
);

    function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return (s >= NREQ) ? IDX_W'(s - NREQ) : IDX_W'(s);
    endfunction

    // First pick: lowest-index overridden candidate, else first candidate from start.
    always_comb begin
        logic             take;
        logic [IDX_W-1:0] j;
        first_vld = 1'b0;
        first_idx = '0;
        take      = 1'b0;
        j         = '0;
        for (int i = 0; i < NREQ; i++) begin
            take      = ovr[i] && !first_vld;
            first_idx = take ? IDX_W'(i) : first_idx;
            first_vld = first_vld | take;
        end
        for (int k = 0; k < NREQ; k++) begin
            j         = rot(start, k);
            take      = cand[j] && !first_vld;
            first_idx = take ? j : first_idx;
            first_vld = first_vld | take;
        end
    end

    // Second pick: next candidate in rotating order that is neither the first nor excluded.
    always_comb begin
        logic             take;
        logic [IDX_W-1:0] j;
        second_vld = 1'b0;
        second_idx = '0;
        take       = 1'b0;
        j          = '0;
        for (int k = 0; k < NREQ; k++) begin
            j          = rot(start, k);
            take       = first_vld && cand[j] && !excl[j] && (j != first_idx) && !second_vld;
            second_idx = take ? j : second_idx;
            second_vld = second_vld | take;
        end
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Writeback scheduler mapping NREQ requesters onto the two register-file write ports.
// Optional macro WB_SCHED_BYPASS_EN adds read-port forwarding from the registered writes.
module wb_port_scheduler
    import mips_wb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [REG_W*NREQ-1:0]  req_wn,
    input  logic [DATA_W*NREQ-1:0] req_d,
    output logic [NREQ-1:0]        req_ready,
    output logic [REG_W-1:0]       wnx,
    output logic [DATA_W-1:0]      dx,
    output logic                   wex,
    output logic [REG_W-1:0]       wny,
    output logic [DATA_W-1:0]      dy,
    output logic                   wey
`ifdef WB_SCHED_BYPASS_EN
    ,
    input  logic [REG_W-1:0]       rna,
    input  logic [REG_W-1:0]       rnb,
    input  logic [DATA_W-1:0]      qa_rf,
    input  logic [DATA_W-1:0]      qb_rf,
    output logic [DATA_W-1:0]      qa,
    output logic [DATA_W-1:0]      qb
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [NREQ-1:0][REG_W-1:0]   wn_s;
    logic [NREQ-1:0][DATA_W-1:0]  d_s;
    logic [NREQ-1:0]              r0_s;
    logic [NREQ-1:0]              cand_s;
    logic [NREQ-1:0]              ovr_s;
    logic [NREQ-1:0]              excl_s;
    logic [NREQ-1:0][WAIT_W-1:0]  wait_r;
    logic [IDX_W-1:0]             rr_ptr_r;
    logic [IDX_W-1:0]             first_idx_s;
    logic [IDX_W-1:0]             second_idx_s;
    logic                         first_vld_s;
    logic                         second_vld_s;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
        return (int'(v) == NREQ - 1) ? '0 : v + IDX_W'(1);
    endfunction

    // Unpack requests; R0 writes are acknowledged at once and never reach a port.
    always_comb begin
        wn_s   = '0;
        d_s    = '0;
        r0_s   = '0;
        cand_s = '0;
        ovr_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            wn_s[i]   = req_wn[REG_W*i +: REG_W];
            d_s[i]    = req_d[DATA_W*i +: DATA_W];
            r0_s[i]   = req_valid[i] && !flush && (wn_s[i] == REG_ZERO);
            cand_s[i] = req_valid[i] && !flush && (wn_s[i] != REG_ZERO);
            ovr_s[i]  = cand_s[i] && (wait_r[i] == WAIT_MAX);
        end
    end

    wb_rr_pick #(.NREQ(NREQ)) u_pick (
        .cand       (cand_s),
        .start      (rr_ptr_r),
        .ovr        (ovr_s),
        .excl       (excl_s),
        .first_idx  (first_idx_s),
        .first_vld  (first_vld_s),
        .second_idx (second_idx_s),
        .second_vld (second_vld_s)
    );

    // Port y may never target the register already claimed by port x.
    always_comb begin
        excl_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            excl_s[i] = (wn_s[i] == wn_s[first_idx_s]);
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = r0_s[i]
                         || (first_vld_s  && (first_idx_s  == IDX_W'(i)))
                         || (second_vld_s && (second_idx_s == IDX_W'(i)));
        end
    end

    // Round-robin pointer moves past the last port-granted requester.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rr_ptr_r <= '0;
        end else if (second_vld_s) begin
            rr_ptr_r <= inc_wrap(second_idx_s);
        end else if (first_vld_s) begin
            rr_ptr_r <= inc_wrap(first_idx_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_r <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush || !req_valid[i] || req_ready[i]) begin
                    wait_r[i] <= '0;
                end else if (wait_r[i] != WAIT_MAX) begin
                    wait_r[i] <= wait_r[i] + WAIT_W'(1);
                end else begin
                    wait_r[i] <= wait_r[i];
                end
            end
        end
    end

    // Empty slots drop the enable but keep the last register number and data.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wex <= 1'b0;
            wnx <= REG_ZERO;
            dx  <= 32'd0;
            wey <= 1'b0;
            wny <= REG_ZERO;
            dy  <= 32'd0;
        end else begin
            wex <= first_vld_s;
            wey <= second_vld_s;
            if (first_vld_s) begin
                wnx <= wn_s[first_idx_s];
                dx  <= d_s[first_idx_s];
            end else begin
                wnx <= wnx;
                dx  <= dx;
            end
            if (second_vld_s) begin
                wny <= wn_s[second_idx_s];
                dy  <= d_s[second_idx_s];
            end else begin
                wny <= wny;
                dy  <= dy;
            end
        end
    end

`ifdef WB_SCHED_BYPASS_EN
    always_comb begin
        if ((rna != REG_ZERO) && wey && (wny == rna)) begin
            qa = dy;
        end else if ((rna != REG_ZERO) && wex && (wnx == rna)) begin
            qa = dx;
        end else begin
            qa = qa_rf;
        end
        if ((rnb != REG_ZERO) && wey && (wny == rnb)) begin
            qb = dy;
        end else if ((rnb != REG_ZERO) && wex && (wnx == rnb)) begin
            qb = dx;
        end else begin
            qb = qb_rf;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed and randomized bench for wb_port_scheduler against a queue-based
// reference model of the grant rules (forwarding checks when WB_SCHED_BYPASS_EN is set).
module tb_wb_port_scheduler;

    localparam int NREQ     = 3;
    localparam int MAX_WAIT = 4;

    logic         clk;
    logic         clr;
    logic         flush;
    logic [2:0]   req_valid;
    logic [14:0]  req_wn;
    logic [95:0]  req_d;
    logic [2:0]   req_ready;
    logic [4:0]   wnx;
    logic [31:0]  dx;
    logic         wex;
    logic [4:0]   wny;
    logic [31:0]  dy;
    logic         wey;
`ifdef WB_SCHED_BYPASS_EN
    logic [4:0]   rna;
    logic [4:0]   rnb;
    logic [31:0]  qa_rf;
    logic [31:0]  qb_rf;
    logic [31:0]  qa;
    logic [31:0]  qb;
`endif

    int n_chk;
    int n_fail;

    int          m_ptr;
    int          m_wait [NREQ];
    logic        m_wex;
    logic        m_wey;
    logic [4:0]  m_wnx;
    logic [4:0]  m_wny;
    logic [31:0] m_dx;
    logic [31:0] m_dy;
    logic [31:0] rf_obs [32];
    logic [2:0]  last_ready;

    wb_port_scheduler #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .req_valid (req_valid),
        .req_wn    (req_wn),
        .req_d     (req_d),
        .req_ready (req_ready),
        .wnx       (wnx),
        .dx        (dx),
        .wex       (wex),
        .wny       (wny),
        .dy        (dy),
        .wey       (wey)
`ifdef WB_SCHED_BYPASS_EN
        ,
        .rna       (rna),
        .rnb       (rnb),
        .qa_rf     (qa_rf),
        .qb_rf     (qb_rf),
        .qa        (qa),
        .qb        (qb)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wn_of(input int i);
        return int'(req_wn[5*i +: 5]);
    endfunction

    function automatic bit cand_of(input int i);
        return req_valid[i] && !flush && (wn_of(i) != 0);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
        m_wex = 1'b0; m_wey = 1'b0;
        m_wnx = 5'd0; m_wny = 5'd0;
        m_dx  = 32'd0; m_dy = 32'd0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #2;
        check("rst_wex", 32'(wex), 32'd0);
        check("rst_wey", 32'(wey), 32'd0);
        check("rst_wnx", 32'(wnx), 32'd0);
        check("rst_dy",  dy,       32'd0);
        clr = 1'b0;
        model_reset();
    endtask

    // One clock: inputs must already be applied; checks ready, then the registered ports.
    task automatic cycle();
        int          ord [$];
        int          x;
        int          y;
        int          j;
        bit          have;
        logic [2:0]  er;
`ifdef WB_SCHED_BYPASS_EN
        logic [31:0] ea;
        logic [31:0] eb;
        rna   = ($urandom_range(0, 3) == 0) ? m_wnx : (($urandom_range(0, 2) == 0) ? m_wny : 5'($urandom_range(0, 31)));
        rnb   = ($urandom_range(0, 3) == 0) ? m_wny : 5'($urandom_range(0, 31));
        qa_rf = $urandom;
        qb_rf = $urandom;
`endif
        #1;
        er = 3'b000; x = -1; y = -1; have = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && !flush && wn_of(i) == 0) er[i] = 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (!have && cand_of(i) && m_wait[i] == MAX_WAIT) begin
                ord.push_back(i);
                have = 1'b1;
            end
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (cand_of(j) && !(have && ord[0] == j)) ord.push_back(j);
        end
        if (ord.size() > 0) begin
            x = ord[0];
            for (int n = 1; n < ord.size(); n++)
                if (y < 0 && wn_of(ord[n]) != wn_of(x)) y = ord[n];
        end
        if (x >= 0) er[x] = 1'b1;
        if (y >= 0) er[y] = 1'b1;
        check("ready", 32'(req_ready), 32'(er));
        last_ready = req_ready;
`ifdef WB_SCHED_BYPASS_EN
        ea = (rna != 0 && m_wey && m_wny == rna) ? m_dy : ((rna != 0 && m_wex && m_wnx == rna) ? m_dx : qa_rf);
        eb = (rnb != 0 && m_wey && m_wny == rnb) ? m_dy : ((rnb != 0 && m_wex && m_wnx == rnb) ? m_dx : qb_rf);
        check("fwd_qa", qa, ea);
        check("fwd_qb", qb, eb);
`endif
        @(posedge clk);
        #1;
        m_wex = (x >= 0);
        m_wey = (y >= 0);
        if (x >= 0) begin m_wnx = 5'(wn_of(x)); m_dx = req_d[32*x +: 32]; end
        if (y >= 0) begin m_wny = 5'(wn_of(y)); m_dy = req_d[32*y +: 32]; end
        if (y >= 0)      m_ptr = (y + 1) % NREQ;
        else if (x >= 0) m_ptr = (x + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (flush || !req_valid[i] || er[i]) m_wait[i] = 0;
            else if (m_wait[i] < MAX_WAIT)       m_wait[i] = m_wait[i] + 1;
        end
        check("wex", 32'(wex), 32'(m_wex));
        check("wey", 32'(wey), 32'(m_wey));
        check("wnx", 32'(wnx), 32'(m_wnx));
        check("wny", 32'(wny), 32'(m_wny));
        check("dx",  dx, m_dx);
        check("dy",  dy, m_dy);
        if (wex) rf_obs[wnx] = dx;
        if (wey) rf_obs[wny] = dy;
    endtask

    initial begin
        int waited;
        n_chk = 0; n_fail = 0;
        clk = 1'b0; clr = 1'b0; flush = 1'b0;
        req_valid = 3'b000; req_wn = 15'd0; req_d = 96'd0;
        last_ready = 3'b000;
`ifdef WB_SCHED_BYPASS_EN
        rna = 5'd0; rnb = 5'd0; qa_rf = 32'd0; qb_rf = 32'd0;
`endif
        for (int r = 0; r < 32; r++) rf_obs[r] = 32'd0;
        model_reset();
        #1;
        do_reset();

        // single request
        req_valid = 3'b001; req_wn[4:0] = 5'd5; req_d[31:0] = 32'hA5A5_0001;
        cycle();
        check("t1_ready0", 32'(last_ready[0]), 32'd1);
        check("t1_wex", 32'(wex), 32'd1);
        check("t1_wnx", 32'(wnx), 32'd5);
        check("t1_dx",  dx, 32'hA5A5_0001);
        check("t1_wey", 32'(wey), 32'd0);

        // three-way contention from rr_ptr=0
        do_reset();
        req_valid = 3'b111; req_wn = {5'd5, 5'd4, 5'd3}; req_d = {32'h33, 32'h22, 32'h11};
        cycle();
        check("t2_c1_ready", 32'(last_ready), 32'b011);
        req_valid = 3'b100;
        cycle();
        check("t2_c2_ready", 32'(last_ready), 32'b100);
        check("t2_c2_wnx", 32'(wnx), 32'd5);
        req_valid = 3'b111;
        cycle();
        check("t2_ptr0_ready", 32'(last_ready), 32'b011);

        // same destination register
        do_reset();
        req_valid = 3'b011; req_wn = {5'd0, 5'd7, 5'd7}; req_d = {32'd0, 32'd2, 32'd1};
        cycle();
        check("t3_c1_ready", 32'(last_ready), 32'b001);
        req_valid = 3'b010;
        cycle();
        check("t3_c2_ready", 32'(last_ready), 32'b010);
        req_valid = 3'b000;
        cycle();
        check("t3_r7", rf_obs[7], 32'd2);

        // R0 request and flush
        req_valid = 3'b010; req_wn = {5'd0, 5'd0, 5'd6};
        cycle();
        check("t4_r0_ready", 32'(last_ready), 32'b010);
        check("t4_r0_we", 32'({wex, wey}), 32'd0);
        flush = 1'b1; req_valid = 3'b001;
        cycle();
        check("t4_fl_ready", 32'(last_ready), 32'b000);
        check("t4_fl_we", 32'({wex, wey}), 32'd0);
        flush = 1'b0; req_valid = 3'b000;
        cycle();

        // starvation guard: all target R7, req2 held
        do_reset();
        req_wn = {5'd7, 5'd7, 5'd7};
        waited = 0;
        for (int c = 0; c < 12; c++) begin
            if (waited == c) begin
                req_valid = 3'b111;
                req_d = {$urandom, $urandom, $urandom};
                cycle();
                if (!last_ready[2]) waited = c + 1;
            end
        end
        check("t5_starve_bound", 32'(waited < 5), 32'd1);
        req_valid = 3'b000;
        cycle();

        // clr mid-transfer drops enables immediately
        req_valid = 3'b001; req_wn = {5'd0, 5'd0, 5'd9}; req_d[31:0] = 32'hDEAD_0009;
        cycle();
        clr = 1'b1;
        #1;
        check("clr_wex", 32'(wex), 32'd0);
        check("clr_wey", 32'(wey), 32'd0);
        #1;
        clr = 1'b0;
        model_reset();
        req_valid = 3'b000;

        // random mixed traffic
        for (int c = 0; c < 300; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            req_wn = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            req_d = {$urandom, $urandom, $urandom};
            flush = ($urandom_range(0, 15) == 0);
            cycle();
        end
        // saturated contention to exercise the wait override
        flush = 1'b0;
        for (int c = 0; c < 200; c++) begin
            req_valid = 3'b111;
            req_wn = {5'($urandom_range(1, 2)), 5'($urandom_range(1, 2)), 5'($urandom_range(1, 2))};
            req_d = {$urandom, $urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Writeback scheduler for the dual-write-port 32x32 register file.
- Arbitrates NREQ writeback requesters (ALU, LSU, MDU by default) onto write ports x and y, at most two writes per cycle.
- Never drives the same register number on both ports, so the register file's port-y priority rule is never exercised.
- Drives the register file write ports from registered outputs.
- Optionally forwards the in-flight writes to the read ports.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- MAX_WAIT, 4, consecutive stalled cycles before a requester is forced to first slot (1..15).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous reset, active-high.
- flush  in  1  drop all requests this cycle, no grants.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_wn  in  5*NREQ  destination register; requester i uses bits [5i+4:5i].
- req_d  in  32*NREQ  write data; requester i uses bits [32i+31:32i].
- req_ready  out  NREQ  combinational grant; a transfer occurs when valid and ready are both high.
- wnx  out  5  port x register number, registered.
- dx  out  32  port x data, registered.
- wex  out  1  port x write enable, registered.
- wny  out  5  port y register number, registered.
- dy  out  32  port y data, registered.
- wey  out  1  port y write enable, registered.

Behaviour:
- Reset (clr=1, async): wex=wey=0, wnx=wny=0, dx=dy=0, rr_ptr=0, all wait_cnt=0.
- req_ready is combinational from the current inputs and state; it is not gated by clr.

Eligibility:
- Requester i is eligible when req_valid[i]=1 and flush=0.

R0 requests:
- Eligible with wn=0: ready=1 in the same cycle.
- Consumes no port and produces no write.
- Does not update rr_ptr or block other requesters.

Candidates and ordering:
- Candidates are eligible requesters with wn!=0.
- Order is round-robin starting at rr_ptr, with one override.
- Override: if any candidate has wait_cnt==MAX_WAIT, the lowest-index such candidate is ordered first.

Slot allocation:
- First candidate takes slot x.
- Next candidate whose wn differs from slot x's wn takes slot y.
- Same-wn losers get ready=0 and retry later.
- All other candidates get ready=0.

Output registers (next edge):
- wex/wnx/dx load from slot x; wey/wny/dy load from slot y.
- An empty slot loads we=0; its wn/d hold their previous values.
- Latency: handshake cycle N, register-file write at edge N+1.

rr_ptr update:
- After any port grant: rr_ptr = (index of last port-granted requester + 1) mod NREQ.
- No port grant: rr_ptr unchanged.

wait_cnt[i]:
- Increments (saturating at MAX_WAIT) when req_valid[i]=1, ready=0 and flush=0.
- Clears on grant, on flush, or when valid=0.

flush:
- All ready=0.
- Next-edge wex=wey=0.
- Writes already registered complete normally.

Boundary cases:
- All NREQ requesters valid with distinct wn: exactly two granted per cycle; no starvation beyond MAX_WAIT+NREQ cycles.
- clr asserted mid-transfer: the registered write is lost and the enables drop immediately.

Optional Feature:
- Macro: WB_SCHED_BYPASS_EN.
- When defined, the block adds these ports:
  - rna  in  5  read register a.
  - rnb  in  5  read register b.
  - qa_rf  in  32  register-file read data a.
  - qb_rf  in  32  register-file read data b.
  - qa  out  32  forwarded read data a.
  - qb  out  32  forwarded read data b.
- Forwarding is combinational, using the registered outputs:
  - qa = dy if wey and wny==rna;
  - else dx if wex and wnx==rna;
  - else qa_rf.
  - qb follows the same rule with rnb.
  - rna=0 always yields qa_rf; likewise rnb=0 yields qb_rf.
- Without the macro: the ports are absent and no forwarding logic is built.

Decomposition:
- Shared package mips_wb_pkg:
  - REG_W=5, DATA_W=32, REG_ZERO=5'd0.
  - Requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
- One sub-module, wb_rr_pick: rotating priority picker.
  - Inputs: candidate vector, start pointer, override vector.
  - Outputs: first index, second index and valid flags, with a same-wn exclusion mask input.
- The scheduler instantiates wb_rr_pick and holds the registers.

Test Plan:
1. Reset then single request: clr pulse, then req0 valid with wn=5, d=32'hA5A5_0001 → ready[0]=1 the same cycle; next edge wex=1, wnx=5, dx=32'hA5A5_0001, wey=0.
2. Three-way contention, rr_ptr=0, wn=3/4/5 → cycle 1 grants req0→x, req1→y; cycle 2 grants req2→x, rr_ptr=0.
3. Same destination: req0 and req1 both wn=7 (d=1, d=2) → only req0 is granted (x); req1 is granted next cycle; the final value of R7 is 2.
4. R0 and flush:
   - req1 wn=0 → ready=1 with no wex/wey.
   - flush with req0 valid → ready=0, next wex=wey=0, wait_cnt[0] stays 0.
5. Starvation guard, MAX_WAIT=4: hold req2 valid while req0 and req1 stream with a conflicting wn equal to req2's → req2 is granted port x within 5 cycles.
6. With WB_SCHED_BYPASS_EN:
   - wey=1, wny=9, dy=32'h1234; rna=9, qa_rf=0 → qa=32'h1234.
   - rna=0 → qa=qa_rf.
